// File: rtl/line_radix_pkg.sv
// Shared types, ASCII constants and helpers for the line re-formatter.
package line_radix_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_CONVERT,
    ST_SEND
  } state_t;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_A_LC = 8'h61;
  localparam logic [7:0] CH_NL   = 8'h0a;
  localparam logic [7:0] CH_CR   = 8'h0d;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_O    = 8'h4f;

  // ceil(width * log10(2)) in fixed point; width*log10(2) is never an integer here.
  function automatic int dec_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (CH_0 + {4'b0000, n}) : (CH_A_LC + {4'b0000, n} - 8'd10);
  endfunction

endpackage

// File: rtl/line_radix_echo_if.sv
// Byte-stream side of the line re-formatter: receiver input, transmitter output, status.
interface line_radix_echo_if;
  logic       input_valid;
  logic [7:0] input_data;
  logic       radix_dec;
  logic       output_busy;
  logic       output_en;
  logic [7:0] output_data;
  logic       busy;
  logic       overrun;

  modport slave (
    input  input_valid, input_data, radix_dec, output_busy,
    output output_en, output_data, busy, overrun
  );

  modport master (
    output input_valid, input_data, radix_dec, output_busy,
    input  output_en, output_data, busy, overrun
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: binary to BCD, done pulses exactly WIDTH cycles after start.
// The first shift happens on the start edge, so bcd is final in the done cycle.
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    sr_q, sr_d;
  logic [DIGITS*4-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                run_q, run_d;
  logic                done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end

    sr_d   = sr_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      bcd_d = {{(DIGITS*4-1){1'b0}}, bin[WIDTH-1]};
      sr_d  = bin << 1;
      cnt_d = CW'(WIDTH - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj[DIGITS*4-2:0], sr_q[WIDTH-1]};
      sr_d  = sr_q << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/line_radix_echo.sv
// Accumulates a decimal line and replies in hex (1-cycle latency) or decimal (WIDTH+1 cycles).
// Reply bytes wait on output_busy; input bytes arriving while busy are dropped and flagged.
module line_radix_echo
  import line_radix_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  line_radix_echo_if.slave io
);
  localparam int DEC_DIGITS = dec_digits(WIDTH);
  localparam int PW         = (DEC_DIGITS > 1) ? $clog2(DEC_DIGITS) : 1;
  localparam logic [WIDTH+3:0] TEN = {{WIDTH{1'b0}}, 4'd10};

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    value_q, value_d;
  logic                err_q, err_d, ovf_q, ovf_d, seen_q, seen_d;
  logic                radix_q, radix_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                last_q, last_d;
  logic                out_en_q, out_en_d;
  logic [7:0]          out_dat_q, out_dat_d;
  logic                overrun_q, overrun_d;

  logic                    conv_start, conv_done;
  logic [DEC_DIGITS*4-1:0] bcd, src;
  logic [PW-1:0]           lead, pos_m1;
  logic [WIDTH+3:0]        prod;
  logic                    accept;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DEC_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (value_q),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Digit source: BCD once a decimal reply is under way, otherwise the binary value as nibbles.
  assign src    = (state_q != ST_ACCUM && radix_q) ? bcd
                                                   : {{(DEC_DIGITS*4-WIDTH){1'b0}}, value_q};
  assign pos_m1 = pos_q - 1'b1;
  assign prod   = ({4'b0000, value_q} * TEN) + {{WIDTH{1'b0}}, io.input_data[3:0]};
  assign accept = out_en_q & ~io.output_busy;

  always_comb begin
    lead = '0;
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (src[i*4 +: 4] != 4'd0) lead = PW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    seen_d     = seen_q;
    radix_d    = radix_q;
    pos_d      = pos_q;
    last_d     = last_q;
    out_en_d   = out_en_q;
    out_dat_d  = out_dat_q;
    conv_start = 1'b0;
    overrun_d  = overrun_q | (io.input_valid & (state_q != ST_ACCUM));

    unique case (state_q)
      ST_ACCUM: begin
        if (io.input_valid) begin
          if (io.input_data >= CH_0 && io.input_data <= CH_9) begin
            value_d = prod[WIDTH-1:0];
            seen_d  = 1'b1;
            if (prod[WIDTH+3:WIDTH] != 4'd0) ovf_d = 1'b1;
          end else if (io.input_data == CH_NL) begin
            radix_d = io.radix_dec;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            seen_d  = 1'b0;
            pos_d   = '0;
            last_d  = 1'b0;
            if (err_q || ovf_q || !seen_q || !io.radix_dec) begin
              state_d  = ST_SEND;
              out_en_d = 1'b1;
              if (err_q)        out_dat_d = CH_E;
              else if (ovf_q)   out_dat_d = CH_O;
              else if (!seen_q) begin
                out_dat_d = CH_NL;
                last_d    = 1'b1;
              end else begin
                out_dat_d = hex_char(src[{lead, 2'b00} +: 4]);
                pos_d     = lead;
              end
            end else begin
              state_d    = ST_CONVERT;
              conv_start = 1'b1;
            end
          end else if (io.input_data != CH_CR) begin
            err_d = 1'b1;
          end
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          state_d   = ST_SEND;
          out_en_d  = 1'b1;
          out_dat_d = hex_char(src[{lead, 2'b00} +: 4]);
          pos_d     = lead;
          last_d    = 1'b0;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (last_q) begin
            state_d   = ST_ACCUM;
            out_en_d  = 1'b0;
            out_dat_d = 8'h00;
            value_d   = '0;
          end else if (pos_q == '0) begin
            out_dat_d = CH_NL;
            last_d    = 1'b1;
          end else begin
            pos_d     = pos_m1;
            out_dat_d = hex_char(src[{pos_m1, 2'b00} +: 4]);
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      value_q   <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      seen_q    <= 1'b0;
      radix_q   <= 1'b0;
      pos_q     <= '0;
      last_q    <= 1'b0;
      out_en_q  <= 1'b0;
      out_dat_q <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      seen_q    <= seen_d;
      radix_q   <= radix_d;
      pos_q     <= pos_d;
      last_q    <= last_d;
      out_en_q  <= out_en_d;
      out_dat_q <= out_dat_d;
      overrun_q <= overrun_d;
    end
  end

  assign io.output_en   = out_en_q;
  assign io.output_data = out_dat_q;
  assign io.busy        = (state_q != ST_ACCUM);
  assign io.overrun     = overrun_q;

endmodule
